frodo_mac_pipe: RTL and testbench

Pipelined, parametrised multiply-accumulate engine for the Frodo matrix arithmetic datapath. It computes d = a*b + c modulo 2^W on every beat, or accumulates a full dot product a0*b0 + a1*b1 + ... + c. Operands a are unsigned; multiplicands b are small signed samples. It has valid/ready handshakes on both sides so it can sit directly between the matrix-operand fetch logic and the result buffer.

---
 rtl/frodo_mac_pipe.sv | 109 ++++++++++
 tb/tb_frodo_mac_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/frodo_mac_pipe.sv
// Two-stage multiply-accumulate: d = a*sext(b) + c mod 2^W, or a running dot product.
// The whole pipe stalls together on output backpressure.
module frodo_mac_pipe #(
  parameter int W  = 16,
  parameter int BW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [W-1:0]  in_c,
  input  logic          in_mode,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_d,
  output logic [CW-1:0] out_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  function automatic logic signed [W-1:0] sext_b(input logic [BW-1:0] b);
    return {{(W-BW){b[BW-1]}}, b};
  endfunction

  // Low W bits of the product are the same whether b is read as signed or unsigned.
  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a,
                                           input logic signed [W-1:0] b);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, $unsigned(b)};
    return full[W-1:0];
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  logic                 en;
  logic                 vld_p1;
  logic [W-1:0]         prod_p1;
  logic [W-1:0]         c_p1;
  logic                 mode_p1;
  logic                 last_p1;
  logic [W-1:0]         acc_p2;
  logic [CW-1:0]        cnt_p2;
  logic                 first_p2;
  logic [W-1:0]         sum_p2;
  logic [CW-1:0]        cnt_nxt_p2;
  logic                 unused_b_hi;

  assign en          = ~out_valid | out_ready;
  assign in_ready    = en;
  assign unused_b_hi = ^in_b[W-1:BW];

  // Stage 1: product and operand capture
  always_ff @(posedge clk) begin
    if (en) begin
      prod_p1 <= mul_mod(in_a, sext_b(in_b[BW-1:0]));
      c_p1    <= in_c;
      mode_p1 <= in_mode;
      last_p1 <= in_last;
    end
  end

  always_comb begin
    sum_p2     = (first_p2 ? c_p1 : acc_p2) + prod_p1;
    cnt_nxt_p2 = first_p2 ? CNT_ONE : sat_inc(cnt_p2);
  end

  // Stage 2: accumulate / emit result
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_d     <= '0;
      out_cnt   <= '0;
      acc_p2    <= '0;
      cnt_p2    <= '0;
      first_p2  <= 1'b1;
    end else if (en) begin
      vld_p1 <= in_valid;
      if (vld_p1) begin
        if (!mode_p1) begin
          out_d     <= prod_p1 + c_p1;
          out_cnt   <= CNT_ONE;
          out_valid <= 1'b1;
        end else begin
          acc_p2   <= sum_p2;
          cnt_p2   <= cnt_nxt_p2;
          first_p2 <= last_p1;
          if (last_p1) begin
            out_d     <= sum_p2;
            out_cnt   <= cnt_nxt_p2;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frodo_mac_pipe.sv
// Directed bench for frodo_mac_pipe: single-shot, dot product, backpressure,
// reset mid-accumulation, interleaving and term-count saturation.
module tb_frodo_mac_pipe;
  localparam int W  = 16;
  localparam int BW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  in_c = '0;
  logic          in_mode = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_d;
  logic [CW-1:0] out_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  res_d[$];
  logic [CW-1:0] res_cnt[$];

  frodo_mac_pipe #(.W(W), .BW(BW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  // Result collector: every completed output handshake, in order
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_d.push_back(out_d);
      res_cnt.push_back(out_cnt);
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic mode, input logic last);
    logic ok;
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c; in_mode = mode; in_last = last;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drive_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_results();
    res_d.delete();
    res_cnt.delete();
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_d !== 16'h0000) begin errors++; $display("FAIL reset_out_d: got %h, required 0000", out_d); end
    checks++; if (out_cnt !== 8'd0) begin errors++; $display("FAIL reset_out_cnt: got %0d, required 0", out_cnt); end
    out_ready = 1'b1;
  endtask

  task automatic test_mode0_signed();
    clear_results();
    drive(16'd3, 16'hFFFE, 16'd10, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m0_early_valid: got %b, required 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL m0_valid: got %b, required 1", out_valid); end
    checks++; if (out_d !== 16'h0004) begin errors++; $display("FAIL m0_d: got %h, required 0004", out_d); end
    checks++; if (out_cnt !== 8'd1) begin errors++; $display("FAIL m0_cnt: got %0d, required 1", out_cnt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m0_valid_drop: got %b, required 0", out_valid); end
  endtask

  task automatic test_mode0_wrap();
    clear_results();
    drive(16'hFFFF, 16'h0007, 16'd5, 1'b0, 1'b0);
    drive(16'hFFFF, 16'h0037, 16'd5, 1'b0, 1'b0);
    idle(4);
    checks++; if (res_d.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d results, required 2", res_d.size()); end
    else begin
      checks++; if (res_d[0] !== 16'hFFFE) begin errors++; $display("FAIL wrap_d: got %h, required FFFE", res_d[0]); end
      checks++; if (res_d[1] !== 16'hFFFE) begin errors++; $display("FAIL wrap_upper_b: got %h, required FFFE", res_d[1]); end
    end
  endtask

  task automatic test_dot_product();
    clear_results();
    drive(16'd1, 16'd2, 16'd100, 1'b1, 1'b0);
    drive(16'd3, 16'd4, 16'd999, 1'b1, 1'b0);
    drive(16'd5, 16'hFFFF, 16'd777, 1'b1, 1'b1);
    idle(5);
    checks++; if (res_d.size() !== 1) begin errors++; $display("FAIL dot_count: got %0d results, required 1", res_d.size()); end
    else begin
      checks++; if (res_d[0] !== 16'h006D) begin errors++; $display("FAIL dot_d: got %h, required 006D", res_d[0]); end
      checks++; if (res_cnt[0] !== 8'd3) begin errors++; $display("FAIL dot_cnt: got %0d, required 3", res_cnt[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_d[4];
    clear_results();
    exp_d[0] = 16'd11; exp_d[1] = 16'd12; exp_d[2] = 16'd13; exp_d[3] = 16'd14;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) drive(W'(i + 1), 16'd1, 16'd10, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        checks++; if (out_d !== 16'd11) begin errors++; $display("FAIL bp_hold_d_a: got %0d, required 11", out_d); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_d !== 16'd11) begin errors++; $display("FAIL bp_hold_d_b: got %0d, required 11", out_d); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b, required 1", out_valid); end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(5);
    checks++; if (res_d.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d results, required 4", res_d.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res_d[i] !== exp_d[i]) begin errors++; $display("FAIL bp_order[%0d]: got %0d, required %0d", i, res_d[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_acc();
    drive(16'd5, 16'd5, 16'd50, 1'b1, 1'b0);
    drive(16'd2, 16'd2, 16'd0, 1'b1, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_results();
    drive(16'd1, 16'd1, 16'd7, 1'b1, 1'b1);
    idle(4);
    checks++; if (res_d.size() !== 1) begin errors++; $display("FAIL rst_acc_count: got %0d results, required 1", res_d.size()); end
    else begin
      checks++; if (res_d[0] !== 16'd8) begin errors++; $display("FAIL rst_acc_d: got %0d, required 8", res_d[0]); end
      checks++; if (res_cnt[0] !== 8'd1) begin errors++; $display("FAIL rst_acc_cnt: got %0d, required 1", res_cnt[0]); end
    end
  endtask

  task automatic test_interleave();
    clear_results();
    drive(16'd2, 16'd3, 16'd1, 1'b1, 1'b0);
    drive(16'd4, 16'd4, 16'd0, 1'b0, 1'b0);
    drive(16'd1, 16'd1, 16'd55, 1'b1, 1'b1);
    idle(5);
    checks++; if (res_d.size() !== 2) begin errors++; $display("FAIL ilv_count: got %0d results, required 2", res_d.size()); end
    else begin
      checks++; if (res_d[0] !== 16'd16) begin errors++; $display("FAIL ilv_m0_d: got %0d, required 16", res_d[0]); end
      checks++; if (res_cnt[0] !== 8'd1) begin errors++; $display("FAIL ilv_m0_cnt: got %0d, required 1", res_cnt[0]); end
      checks++; if (res_d[1] !== 16'd8) begin errors++; $display("FAIL ilv_dot_d: got %0d, required 8", res_d[1]); end
      checks++; if (res_cnt[1] !== 8'd2) begin errors++; $display("FAIL ilv_dot_cnt: got %0d, required 2", res_cnt[1]); end
    end
  endtask

  task automatic test_cnt_saturate();
    clear_results();
    for (int i = 0; i < 300; i++) drive(16'd1, 16'd1, 16'd0, 1'b1, 1'b0);
    drive(16'd1, 16'd1, 16'd0, 1'b1, 1'b1);
    idle(4);
    checks++; if (res_d.size() !== 1) begin errors++; $display("FAIL sat_count: got %0d results, required 1", res_d.size()); end
    else begin
      checks++; if (res_d[0] !== 16'd301) begin errors++; $display("FAIL sat_d: got %0d, required 301", res_d[0]); end
      checks++; if (res_cnt[0] !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d, required 255", res_cnt[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_signed();
    test_mode0_wrap();
    test_dot_product();
    test_backpressure();
    test_reset_mid_acc();
    test_interleave();
    test_cnt_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
